// File: rtl/wb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : wb_regfile_sb
//  Brief    : Writeback-side 32x32 register file with a per-register
//             pending-write scoreboard. Optional macro WB_REGFILE_BYPASS_EN
//             adds write-through bypass on the read ports.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_regfile_sb #(
   parameter int NREGS        = 32,
   parameter int MAX_INFLIGHT = 3
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        wb_advance,
   input  logic        wb_regWEN,
   input  logic [4:0]  wb_write_reg,
   input  logic [31:0] wb_write_data,
   input  logic        iss_valid,
   input  logic        iss_regWEN,
   input  logic [4:0]  iss_write_reg,
   input  logic        flush,
   input  logic [4:0]  rsel1,
   input  logic [4:0]  rsel2,
   output logic [31:0] rdat1,
   output logic [31:0] rdat2,
   output logic        busy1,
   output logic        busy2,
   output logic        sb_err
);

   localparam int c_CNTW = $clog2(MAX_INFLIGHT + 1);
   localparam logic [c_CNTW-1:0] c_MAX = c_CNTW'(MAX_INFLIGHT);

   logic [31:0]       w_regs [NREGS];
   logic [c_CNTW-1:0] w_cnt  [NREGS];
   logic [NREGS-1:0]  w_err_vec;
   logic              r_sb_err;

   for (genvar r = 0; r < NREGS; r++) begin : g_reg
      if (r == 0) begin : g_zero
         assign w_regs[r]    = '0;
         assign w_cnt[r]     = '0;
         assign w_err_vec[r] = 1'b0;
      end else begin : g_live
         localparam logic [4:0] c_IDX = 5'(r);
         logic [31:0]       r_data;
         logic [c_CNTW-1:0] r_cnt;
         logic              w_inc;
         logic              w_dec;

         assign w_inc = iss_valid & iss_regWEN & (iss_write_reg == c_IDX);
         // dec doubles as the commit strobe since this register is never r0
         assign w_dec = wb_advance & wb_regWEN & (wb_write_reg == c_IDX);

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               r_data <= '0;
            end else if (w_dec) begin
               r_data <= wb_write_data;
            end
         end

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               r_cnt <= '0;
            end else if (flush) begin
               r_cnt <= '0;
            end else if (w_inc && !w_dec && (r_cnt != c_MAX)) begin
               r_cnt <= r_cnt + 1'b1;
            end else if (w_dec && !w_inc && (r_cnt != '0)) begin
               r_cnt <= r_cnt - 1'b1;
            end
         end

         assign w_regs[r]    = r_data;
         assign w_cnt[r]     = r_cnt;
         assign w_err_vec[r] = ~flush & (
                                  (w_inc & ~w_dec & (r_cnt == c_MAX)) |
                                  (w_dec & ~w_inc & (r_cnt == '0)));
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_sb_err <= 1'b0;
      end else if (|w_err_vec) begin
         r_sb_err <= 1'b1;
      end
   end

   assign sb_err = r_sb_err;

`ifdef WB_REGFILE_BYPASS_EN
   localparam logic [c_CNTW-1:0] c_ONE = c_CNTW'(1);

   logic w_commit;
   logic w_iss_same;
   logic w_byp1;
   logic w_byp2;

   assign w_commit   = wb_advance & wb_regWEN & (wb_write_reg != 5'd0);
   assign w_iss_same = iss_valid & iss_regWEN & (iss_write_reg == wb_write_reg);
   assign w_byp1     = w_commit & (rsel1 == wb_write_reg);
   assign w_byp2     = w_commit & (rsel2 == wb_write_reg);

   assign rdat1 = w_byp1 ? wb_write_data : w_regs[rsel1];
   assign rdat2 = w_byp2 ? wb_write_data : w_regs[rsel2];
   // Hide busy only when this retirement drains the last pending write
   assign busy1 = (w_cnt[rsel1] != '0) & ~(w_byp1 & ~w_iss_same & (w_cnt[rsel1] == c_ONE));
   assign busy2 = (w_cnt[rsel2] != '0) & ~(w_byp2 & ~w_iss_same & (w_cnt[rsel2] == c_ONE));
`else
   assign rdat1 = w_regs[rsel1];
   assign rdat2 = w_regs[rsel2];
   assign busy1 = (w_cnt[rsel1] != '0);
   assign busy2 = (w_cnt[rsel2] != '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_regfile_sb
//  Brief    : Directed self-checking bench for wb_regfile_sb (either setting
//             of WB_REGFILE_BYPASS_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile_sb;

   logic        CLK = 1'b0;
   logic        RST;
   logic        wb_advance;
   logic        wb_regWEN;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_write_data;
   logic        iss_valid;
   logic        iss_regWEN;
   logic [4:0]  iss_write_reg;
   logic        flush;
   logic [4:0]  rsel1;
   logic [4:0]  rsel2;
   logic [31:0] rdat1;
   logic [31:0] rdat2;
   logic        busy1;
   logic        busy2;
   logic        sb_err;

   int checks = 0;
   int errors = 0;

   wb_regfile_sb #(.NREGS(32), .MAX_INFLIGHT(3)) dut (
      .CLK(CLK), .RST(RST),
      .wb_advance(wb_advance), .wb_regWEN(wb_regWEN),
      .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data),
      .iss_valid(iss_valid), .iss_regWEN(iss_regWEN), .iss_write_reg(iss_write_reg),
      .flush(flush), .rsel1(rsel1), .rsel2(rsel2),
      .rdat1(rdat1), .rdat2(rdat2), .busy1(busy1), .busy2(busy2), .sb_err(sb_err)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle();
      wb_advance = 0; wb_regWEN = 0; wb_write_reg = 0; wb_write_data = 0;
      iss_valid = 0; iss_regWEN = 0; iss_write_reg = 0; flush = 0;
   endtask

   task automatic commit(input logic [4:0] r, input logic [31:0] d);
      wb_advance = 1; wb_regWEN = 1; wb_write_reg = r; wb_write_data = d;
   endtask

   task automatic issue(input logic [4:0] r);
      iss_valid = 1; iss_regWEN = 1; iss_write_reg = r;
   endtask

   initial begin
      RST = 1; idle(); rsel1 = 0; rsel2 = 0;
      step();
      // Reset state across every register
      for (int i = 0; i < 32; i++) begin
         rsel1 = 5'(i); rsel2 = 5'(31 - i);
         #1;
         check("rst_rdat1", rdat1, 32'h0);
         check("rst_rdat2", rdat2, 32'h0);
         check("rst_busy1", {31'b0, busy1}, 32'h0);
         check("rst_busy2", {31'b0, busy2}, 32'h0);
      end
      check("rst_sb_err", {31'b0, sb_err}, 32'h0);
      RST = 0;
      step();

      // Commit r5 with no pending issue: data lands and underflow is flagged
      commit(5'd5, 32'hDEADBEEF);
      step(); idle();
      rsel1 = 5'd5; #1;
      check("r5_write", rdat1, 32'hDEADBEEF);
      check("r5_underflow_err", {31'b0, sb_err}, 32'h1);
      RST = 1; #1;
      check("r5_async_rst", rdat1, 32'h0);
      check("async_rst_err", {31'b0, sb_err}, 32'h0);
      step(); RST = 0; step();

      // Issue then retire r7
      issue(5'd7);
      step(); idle();
      rsel1 = 5'd7; #1;
      check("r7_busy_issued", {31'b0, busy1}, 32'h1);
      commit(5'd7, 32'h12345678);
      step(); idle(); #1;
      check("r7_rdat", rdat1, 32'h12345678);
      check("r7_busy_retired", {31'b0, busy1}, 32'h0);
      check("r7_err", {31'b0, sb_err}, 32'h0);

      // Simultaneous issue/retire of r9 with count 1
      issue(5'd9);
      step(); idle();
      rsel1 = 5'd9; issue(5'd9); commit(5'd9, 32'h99990001); #1;
`ifdef WB_REGFILE_BYPASS_EN
      check("r9_same_cycle_rdat", rdat1, 32'h99990001);
`else
      check("r9_same_cycle_rdat", rdat1, 32'h0);
`endif
      check("r9_same_cycle_busy", {31'b0, busy1}, 32'h1);
      step(); idle(); #1;
      check("r9_busy_after", {31'b0, busy1}, 32'h1);
      check("r9_rdat_after", rdat1, 32'h99990001);
      check("r9_err", {31'b0, sb_err}, 32'h0);
      // Final retire of r9 drains the count from 1 to 0
      commit(5'd9, 32'h99990002); #1;
`ifdef WB_REGFILE_BYPASS_EN
      check("r9_drain_rdat", rdat1, 32'h99990002);
      check("r9_drain_busy", {31'b0, busy1}, 32'h0);
`else
      check("r9_drain_rdat", rdat1, 32'h99990001);
      check("r9_drain_busy", {31'b0, busy1}, 32'h1);
`endif
      step(); idle(); #1;
      check("r9_drained_busy", {31'b0, busy1}, 32'h0);
      check("r9_drained_rdat", rdat1, 32'h99990002);

      // Register 0 is hard-wired
      commit(5'd0, 32'hFFFFFFFF); issue(5'd0);
      step(); idle();
      rsel1 = 5'd0; #1;
      check("r0_rdat", rdat1, 32'h0);
      check("r0_busy", {31'b0, busy1}, 32'h0);
      check("r0_err", {31'b0, sb_err}, 32'h0);

      // Overflow on r3
      rsel2 = 5'd3;
      for (int i = 0; i < 3; i++) begin
         issue(5'd3); step();
      end
      idle(); #1;
      check("r3_busy_at_max", {31'b0, busy2}, 32'h1);
      check("r3_err_at_max", {31'b0, sb_err}, 32'h0);
      issue(5'd3); step(); idle(); #1;
      check("r3_overflow_err", {31'b0, sb_err}, 32'h1);
      for (int i = 0; i < 3; i++) begin
         commit(5'd3, 32'h30 + 32'(i)); step();
      end
      idle(); #1;
      check("r3_busy_drained", {31'b0, busy2}, 32'h0);
      commit(5'd3, 32'h00000033); step(); idle(); #1;
      check("r3_underflow_data", rdat2, 32'h00000033);
      check("r3_underflow_busy", {31'b0, busy2}, 32'h0);
      check("r3_err_sticky", {31'b0, sb_err}, 32'h1);

      // Flush with concurrent commit
      issue(5'd4); step();
      issue(5'd6); step(); idle();
      rsel1 = 5'd4; rsel2 = 5'd6; #1;
      check("r4_busy_pre_flush", {31'b0, busy1}, 32'h1);
      check("r6_busy_pre_flush", {31'b0, busy2}, 32'h1);
      flush = 1; commit(5'd4, 32'h000000A5); step(); idle(); #1;
      check("r4_busy_flushed", {31'b0, busy1}, 32'h0);
      check("r6_busy_flushed", {31'b0, busy2}, 32'h0);
      check("r4_flush_rdat", rdat1, 32'h000000A5);
      check("flush_err_sticky", {31'b0, sb_err}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/wb_regfile_sb.md
Name: wb_regfile_sb

Overview:
- Receiving end of the writeback stage. Consumes the stage's final write data, register-write enable and destination register, and commits them to a 32x32 register file.
- A per-register pending-write scoreboard is kept. The issue side marks destinations busy; writeback retirement clears them. The hazard logic reads the busy flags to stall dependent instructions.

Parameters:
- NREGS, 32, number of architectural registers (index width = 5).
- MAX_INFLIGHT, 3, maximum outstanding writes per register. Counter width = clog2(MAX_INFLIGHT+1).

Ports:
- CLK  in  1  system clock, rising-edge.
- RST  in  1  asynchronous, active-high reset.
- wb_advance  in  1  writeback stage advances this cycle (ihit/dhit-qualified pipeline enable).
- wb_regWEN  in  1  writeback register write enable (writeback regWEN_out).
- wb_write_reg  in  5  destination register (writeback write_reg_out).
- wb_write_data  in  32  data to commit (writeback final_write_data).
- iss_valid  in  1  an instruction issues this cycle.
- iss_regWEN  in  1  issuing instruction writes a register.
- iss_write_reg  in  5  destination of issuing instruction.
- flush  in  1  synchronous pipeline flush; clears all pending counts.
- rsel1  in  5  read select port 1.
- rsel2  in  5  read select port 2.
- rdat1  out  32  read data port 1.
- rdat2  out  32  read data port 2.
- busy1  out  1  rsel1 has at least one pending write.
- busy2  out  1  rsel2 has at least one pending write.
- sb_err  out  1  sticky scoreboard overflow/underflow flag.

Behaviour:
- Reset (async, RST=1): all registers 0, all pending counters 0, sb_err 0. rdat1/rdat2/busy1/busy2 are combinational from reset state, so they are 0.
- Commit: write happens on a CLK rising edge when wb_advance & wb_regWEN & (wb_write_reg != 0). Written data is visible on rdat the following cycle (latency 1).
- Register 0: reads return 0, writes are ignored, the counter is never incremented, busy is never asserted.
- Reads are combinational, indexed by rsel.
- Scoreboard, per register r != 0:
  - inc = iss_valid & iss_regWEN & iss_write_reg==r.
  - dec = wb_advance & wb_regWEN & wb_write_reg==r.
  - inc&dec: count unchanged (simultaneous issue and retire of the same register).
  - inc only: count+1.
  - dec only: count-1.
- Overflow: inc only with count==MAX_INFLIGHT → count holds, sb_err set.
- Underflow: dec only with count==0 → count stays 0, sb_err set. The register write itself still occurs.
- busyN = (count[rselN] != 0), combinational; no same-cycle view of this cycle's inc/dec.
- flush=1: all counters cleared on the edge. flush overrides inc/dec in that cycle. A concurrent commit still writes the register file.
- sb_err clears only on reset.
- Reset mid-operation: any in-flight write in that cycle is lost and the counters clear.

Optional Feature:
- Macro WB_REGFILE_BYPASS_EN.
- Defined: write-through bypass. If a commit is occurring this cycle and rselN == wb_write_reg != 0, rdatN = wb_write_data combinationally. busyN is also masked to 0 when that commit brings the count from 1 to 0.
- Undefined: rdatN returns the pre-write stored value, and busyN follows the stored count only.

Test Plan:
- Reset then read all 32 registers → rdat1=rdat2=0, busy=0, sb_err=0. Assert RST mid-run after writing r5=0xDEADBEEF → r5 reads 0 immediately.
- Issue r7 (count 1). Retire wb_write_reg=7, data=0x12345678, wb_advance=1 → next cycle rdat1(rsel1=7)=0x12345678, busy1=0.
- Same cycle: issue r9 while retiring r9, with count=1 → count stays 1, busy=1. With WB_REGFILE_BYPASS_EN, same-cycle rdat(9)=wb_write_data. Without it, rdat returns the old value.
- Write r0=0xFFFFFFFF and issue r0 → rdat(0)=0, busy(0)=0.
- Issue r3 four times with MAX_INFLIGHT=3 → count 3, sb_err=1. Retire r3 when count is 0 → sb_err=1, data still written.
- Issue r4 and r6, then pulse flush with a simultaneous commit to r4=0xA5 → busy(4)=busy(6)=0, rdat(4)=0xA5.
